pe_param: RTL
=============

# pe_param

Parametrised systolic processing element, successor to the fixed 8/20-bit PE. It supports both output-stationary (OS) and weight-stationary (WS) dataflows selected per beat, double-buffered accumulators swapped by a propagate bit, and round-half-up shifting with output saturation. Each instance is one cell of the mesh: `a` flows east, `b`/`d` and control flow south, and every output is registered.

## Interface
Parameters:
- `IN_W`, 8: width of signed `a` operand.
- `OUT_W`, 20: width of signed `b`, `d`, `out_b`, `out_c`.
- `ACC_W`, 32: width of the internal accumulators `c1`/`c2`.
- `SHIFT_W`, 5: width of the control shift amount.
- `ID_W`, 3: width of the tag `id`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: beat valid for all input lanes.
- `in_a`, in, IN_W: signed activation.
- `in_b`, in, OUT_W: signed OS weight / WS partial sum.
- `in_d`, in, OUT_W: signed preload value.
- `in_dataflow`, in, 1: 0 = OS, 1 = WS.
- `in_propagate`, in, 1: accumulator select.
- `in_shift`, in, SHIFT_W: OS output right-shift amount.
- `in_id`, in, ID_W: tag, passed through.
- `in_last`, in, 1: last-beat marker, passed through.
- `out_valid`, out, 1: registered `in_valid`.
- `out_a`, out, IN_W: registered copy of `in_a`.
- `out_b`, out, OUT_W: registered B result.
- `out_c`, out, OUT_W: registered C result.
- `out_dataflow`, `out_propagate`, `out_shift`, `out_id`, `out_last`, out, matching widths: registered control.

## Operation
- A beat is a cycle with `in_valid`=1. With `in_valid`=0, `c1`, `c2` and all payload output flops hold, and `out_valid` goes to 0.
- Let P = `in_a`·`in_b`, a signed product sign-extended to ACC_W. All ACC_W arithmetic wraps in two's complement.
- OS, propagate=1:
  - `out_c` = sat(rnd(c1, shift)).
  - `c1` ← sext(`in_d`).
  - `c2` ← `c2` + P.
  - `out_b` = `in_b`.
- OS, propagate=0: the same with the roles of `c1` and `c2` swapped.
- WS, propagate=1:
  - `c1` ← sext(`in_d`) (weight preload).
  - `out_b` = trunc_OUT_W(`in_b` + `in_a`·`c2`).
  - `out_c` = trunc_OUT_W(`c1`) (value before the update).
- WS, propagate=0: the same with the roles of `c1` and `c2` swapped.
- rnd(x, s):
  - s=0 → x.
  - Otherwise (x + 2^(s−1)) >>> s (arithmetic shift, round half toward +∞).
  - s ≥ ACC_W → 0 for x ≥ 0, −1 for x < 0.
- sat(x): clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- `out_a`, shift, id, last, dataflow and propagate copy the inputs on each beat.
- A dataflow change between consecutive beats needs no flush. The next beat uses the accumulator contents as they stand.

## Timing
- Latency 1: beat inputs at edge k appear on the outputs after edge k+1. Throughput is one beat per cycle.
- No backpressure. The downstream PE must accept every beat.
- Reset value of every output, `c1` and `c2` is 0. Assertion is asynchronous; release is synchronised by the mesh reset tree.
- Reset asserted mid-stream: the in-flight beat is discarded, the accumulators clear, and `out_valid`=0 until the first post-reset beat plus 1 cycle.
- Accumulator read and update in the same beat: reads always use pre-edge values.

## Structure
- Shared package `pe_pkg` contains:
  - `dataflow_e` enum: OS=0, WS=1.
  - `pe_ctrl_t` struct: dataflow, propagate, shift.
  - functions `rnd_shift` and `sat_clip`, parametrised by widths.
  - default width constants.
- No sub-module. One always_ff for state and outputs, one always_comb for the datapath.

## Test plan
- Reset: run 5 OS beats, then assert `rst` low mid-beat → all outputs 0 immediately, and after release a read of `c1` gives `out_c`=0.
- OS accumulate: defaults; 3 beats with prop=0, a=3, b=4, d=0; then 1 beat with prop=1, shift=0 → `out_c`=36 one cycle later, `out_b`=`in_b`.
- Rounding and saturation:
  - `c1`=37, shift=2 → `out_c`=9.
  - `c1`=−6, shift=2 → `out_c`=−1.
  - `c1`=2^20, shift=0 → `out_c`=524287.
- WS:
  - Beat with prop=1, d=5 (loads `c1`=5).
  - Beat with prop=0, a=−2, b=100 → `out_b`=90, `out_c`=trunc(`c2`).
- Valid gaps: alternate `in_valid` 1/0 over 8 cycles → `out_valid` is the input pattern delayed 1, payload holds during gaps, and final `c1` matches the model computed over valid beats only.
- Back-to-back OS→WS→OS with wrap-around (`c2` = 2^31−1, then +1) → `c2` = −2^31, no saturation, and all results match the reference model.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the parametrised systolic PE.
// The helpers work on 64-bit signed values so one function serves any width up to 64.
package pe_pkg;

  localparam int DEF_IN_W    = 8;
  localparam int DEF_OUT_W   = 20;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_SHIFT_W = 5;
  localparam int DEF_ID_W    = 3;

  // Shift field is sized for the widest supported SHIFT_W; narrower shifts zero-extend.
  localparam int CTRL_SHIFT_W = 8;

  typedef enum logic {
    OS = 1'b0,
    WS = 1'b1
  } dataflow_e;

  typedef struct packed {
    dataflow_e                 dataflow;
    logic                      propagate;
    logic [CTRL_SHIFT_W-1:0]   shift;
  } pe_ctrl_t;

  // Reinterpret the low w bits of x as a signed w-bit value.
  function automatic logic signed [63:0] wrap_to(input logic signed [63:0] x,
                                                 input int unsigned w);
    logic signed [63:0] t;
    t = x <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  // Round half toward +inf, then arithmetic shift; the rounding add wraps at acc_w.
  function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] x,
                                                   input int unsigned s,
                                                   input int unsigned acc_w);
    logic signed [63:0] half;
    logic signed [63:0] sum;
    if (s == 0) begin
      return x;
    end
    if (s >= acc_w) begin
      return x[63] ? -64'sd1 : 64'sd0;
    end
    half = 64'sd1 <<< (s - 1);
    sum  = wrap_to(x + half, acc_w);
    return sum >>> s;
  endfunction

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                  input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/pe_param.sv
// One mesh cell: OS/WS multiply-accumulate with double-buffered accumulators.
// All outputs are registered; a flows east, b/d and control flow south.
module pe_param
  import pe_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [IN_W-1:0]   in_a,
  input  logic signed [OUT_W-1:0]  in_b,
  input  logic signed [OUT_W-1:0]  in_d,
  input  logic                     in_dataflow,
  input  logic                     in_propagate,
  input  logic [SHIFT_W-1:0]       in_shift,
  input  logic [ID_W-1:0]          in_id,
  input  logic                     in_last,
  output logic                     out_valid,
  output logic signed [IN_W-1:0]   out_a,
  output logic signed [OUT_W-1:0]  out_b,
  output logic signed [OUT_W-1:0]  out_c,
  output logic                     out_dataflow,
  output logic                     out_propagate,
  output logic [SHIFT_W-1:0]       out_shift,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last
);

  logic signed [ACC_W-1:0] c1_reg, c1_next;
  logic signed [ACC_W-1:0] c2_reg, c2_next;
  logic signed [OUT_W-1:0] b_reg, b_next;
  logic signed [OUT_W-1:0] c_reg, c_next;
  logic signed [IN_W-1:0]  a_reg;
  logic                    valid_reg;
  logic                    dataflow_reg;
  logic                    propagate_reg;
  logic [SHIFT_W-1:0]      shift_reg;
  logic [ID_W-1:0]         id_reg;
  logic                    last_reg;

  pe_ctrl_t                ctrl_in;
  logic signed [ACC_W-1:0] a_ext, b_ext, d_ext, prod;
  logic signed [ACC_W-1:0] sel_acc, oth_acc, sel_next, oth_next;

  // sel_acc is the buffer being drained/preloaded this beat, oth_acc the one in use.
  always_comb begin
    ctrl_in  = '{dataflow:  dataflow_e'(in_dataflow),
                 propagate: in_propagate,
                 shift:     CTRL_SHIFT_W'(in_shift)};
    a_ext    = ACC_W'(in_a);
    b_ext    = ACC_W'(in_b);
    d_ext    = ACC_W'(in_d);
    prod     = a_ext * b_ext;
    sel_acc  = ctrl_in.propagate ? c1_reg : c2_reg;
    oth_acc  = ctrl_in.propagate ? c2_reg : c1_reg;
    sel_next = d_ext;
    oth_next = oth_acc;
    b_next   = b_reg;
    c_next   = c_reg;

    if (ctrl_in.dataflow == OS) begin
      c_next   = OUT_W'(sat_clip(rnd_shift(64'(sel_acc), 32'(ctrl_in.shift), ACC_W), OUT_W));
      b_next   = in_b;
      oth_next = oth_acc + prod;
    end else begin
      c_next   = sel_acc[OUT_W-1:0];
      b_next   = OUT_W'(b_ext + a_ext * oth_acc);
    end

    c1_next = ctrl_in.propagate ? sel_next : oth_next;
    c2_next = ctrl_in.propagate ? oth_next : sel_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg     <= 1'b0;
      c1_reg        <= '0;
      c2_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      dataflow_reg  <= 1'b0;
      propagate_reg <= 1'b0;
      shift_reg     <= '0;
      id_reg        <= '0;
      last_reg      <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        c1_reg        <= c1_next;
        c2_reg        <= c2_next;
        a_reg         <= in_a;
        b_reg         <= b_next;
        c_reg         <= c_next;
        dataflow_reg  <= in_dataflow;
        propagate_reg <= in_propagate;
        shift_reg     <= in_shift;
        id_reg        <= in_id;
        last_reg      <= in_last;
      end
    end
  end

  assign out_valid     = valid_reg;
  assign out_a         = a_reg;
  assign out_b         = b_reg;
  assign out_c         = c_reg;
  assign out_dataflow  = dataflow_reg;
  assign out_propagate = propagate_reg;
  assign out_shift     = shift_reg;
  assign out_id        = id_reg;
  assign out_last      = last_reg;

endmodule
